fifo_packer_nx1: RTL and testbench

Parametrised successor to the DIGIFIFO 32→64 converter. It reads IN_W-bit words from a standard-mode source FIFO (one-cycle read latency) in counted bursts and packs RATIO consecutive words into one RATIO·IN_W-bit word. It writes each packed word to a FWFT destination FIFO that feeds the DDR3 writer. New relative to the 2:1 converter: any width and ratio, exact-length bursts that cannot underflow the source, a word-count status output, and an optional padded flush of a partial word at end of run.

---
 rtl/fifo_packer_pkg.sv | 17 +
 rtl/fifo_packer_nx1_lane_reg.sv | 52 +++++
 rtl/fifo_packer_nx1.sv | 141 ++++++++++++++
 tb/tb_fifo_packer_nx1.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_packer_pkg.sv
// Shared types and constants for the N:1 FIFO packer (fifo_packer_nx1).
package fifo_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_PAD = 32'hF0F0_F0F0;

  function automatic int out_width(input int in_w, input int ratio);
    return in_w * ratio;
  endfunction

endpackage

// File: rtl/fifo_packer_nx1_lane_reg.sv
// Lane register for the packer: RATIO lanes of IN_W bits, write index and PAD prefill.
module packer_lane_reg
  import fifo_packer_pkg::*;
#(
  parameter int              IN_W  = 32,
  parameter int              RATIO = 2,
  parameter logic [IN_W-1:0] PAD   = IN_W'(DEFAULT_PAD)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_en,
  input  logic [IN_W-1:0]                     wr_data,
  input  logic                                clear,
  output logic [out_width(IN_W, RATIO)-1:0]   word_next,
  output logic [out_width(IN_W, RATIO)-1:0]   word_cur,
  output logic                                full_next,
  output logic                                partial
);

  localparam int IDX_W = $clog2(RATIO);

  logic [RATIO-1:0][IN_W-1:0] lanes;
  logic [RATIO-1:0][IN_W-1:0] lanes_nxt;
  logic [IDX_W-1:0]           idx;

  // word_next is the word as it looks once the incoming lane lands this cycle
  always_comb begin
    lanes_nxt = lanes;
    if (wr_en) lanes_nxt[idx] = wr_data;
  end

  assign word_next = lanes_nxt;
  assign word_cur  = lanes;
  assign full_next = wr_en && (idx == IDX_W'(RATIO - 1));
  assign partial   = (idx != '0);

  // Lanes are re-filled with PAD whenever a word completes, so a flushed
  // partial word already carries PAD in every unwritten lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes <= {RATIO{PAD}};
      idx   <= '0;
    end else if (clear || full_next) begin
      lanes <= {RATIO{PAD}};
      idx   <= '0;
    end else if (wr_en) begin
      lanes[idx] <= wr_data;
      idx        <= idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/fifo_packer_nx1.sv
// N:1 width packer from a standard-mode source FIFO into a FWFT destination FIFO.
// Optional padded end-of-run flush is enabled with `define FIFO_PACKER_FLUSH_EN.
module fifo_packer_nx1
  import fifo_packer_pkg::*;
#(
  parameter int              IN_W  = 32,
  parameter int              RATIO = 2,
  parameter int              CNT_W = 17,
  parameter int              BURST = 256,
  parameter logic [IN_W-1:0] PAD   = IN_W'(DEFAULT_PAD)
) (
  input  logic                               digiclk_i,
  input  logic                               reset_i,
  input  logic [CNT_W-1:0]                   src_rdcnt_i,
  input  logic [IN_W-1:0]                    src_data_i,
  output logic                               src_re_o,
  input  logic                               dst_afull_i,
  output logic                               dst_we_o,
  output logic [out_width(IN_W, RATIO)-1:0]  dst_data_o,
  input  logic                               mem_en_i,
  input  logic                               ddr_full_i,
  input  logic                               last_write_i,
  output logic                               busy_o,
  output logic [31:0]                        words_out_o,
  output state_t                             dbg_state
);

  localparam int OUT_W = out_width(IN_W, RATIO);

  // Handshake: src_re_o requests one word, which is valid on src_data_i the
  // following cycle (no ready); dst_we_o is a one-cycle write with no backpressure
  // other than dst_afull_i, which is registered before it gates reads.

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             armed, afull_q, rd_q;
  logic             flush_emit, drain_done;
  logic [OUT_W-1:0] word_next, word_cur;
  logic             full_next, partial;

`ifdef FIFO_PACKER_FLUSH_EN
  logic flush_pend, flush_act;
`else
  logic flush_act;
  assign flush_act = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    src_re_o   = 1'b0;
    flush_emit = 1'b0;
    drain_done = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (armed && (src_rdcnt_i >= CNT_W'(BURST))) begin
          state_nxt = ST_BURST;
          cnt_nxt   = CNT_W'(BURST);
        end
`ifdef FIFO_PACKER_FLUSH_EN
        else if (flush_pend && (src_rdcnt_i != '0) && (src_rdcnt_i < CNT_W'(BURST))) begin
          state_nxt = ST_FLUSH;
          cnt_nxt   = src_rdcnt_i;
        end
`endif
      end
      ST_BURST, ST_FLUSH: begin
        src_re_o = !afull_q;
        if (!afull_q) begin
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave once the final read's data has been captured into the lanes
        if (!rd_q) begin
          state_nxt  = ST_IDLE;
          drain_done = 1'b1;
          flush_emit = flush_act && partial;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge digiclk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      armed       <= 1'b0;
      afull_q     <= 1'b0;
      rd_q        <= 1'b0;
      dst_we_o    <= 1'b0;
      dst_data_o  <= '0;
      words_out_o <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      afull_q <= dst_afull_i;
      rd_q    <= src_re_o;
      if (last_write_i)                 armed <= 1'b0;
      else if (mem_en_i && !ddr_full_i) armed <= 1'b1;
      dst_we_o <= full_next || flush_emit;
      if (full_next || flush_emit) begin
        dst_data_o  <= flush_emit ? word_cur : word_next;
        words_out_o <= words_out_o + 32'd1;
      end
    end
  end

`ifdef FIFO_PACKER_FLUSH_EN
  always_ff @(posedge digiclk_i or posedge reset_i) begin
    if (reset_i) begin
      flush_pend <= 1'b0;
      flush_act  <= 1'b0;
    end else begin
      if (state == ST_IDLE && state_nxt == ST_FLUSH) flush_act <= 1'b1;
      else if (drain_done)                           flush_act <= 1'b0;
      if (last_write_i) flush_pend <= 1'b1;
      else if ((drain_done && flush_act) || (state == ST_IDLE && src_rdcnt_i == '0))
        flush_pend <= 1'b0;
    end
  end
`endif

  packer_lane_reg #(.IN_W(IN_W), .RATIO(RATIO), .PAD(PAD)) u_lanes (
    .clk       (digiclk_i),
    .rst       (reset_i),
    .wr_en     (rd_q),
    .wr_data   (src_data_i),
    .clear     (flush_emit),
    .word_next (word_next),
    .word_cur  (word_cur),
    .full_next (full_next),
    .partial   (partial)
  );

  assign busy_o    = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_fifo_packer_nx1.sv
// Randomized bench for fifo_packer_nx1 (RATIO=4, BURST=16) with a queue-based source and scoreboard.
module tb_fifo_packer_nx1;
  import fifo_packer_pkg::*;

  localparam int IN_W = 32, RATIO = 4, CNT_W = 17, BURST = 16;
  localparam int OUT_W = IN_W * RATIO;
  localparam logic [IN_W-1:0] PAD = 32'hF0F0_F0F0;

  // clock / reset
  logic digiclk_i = 1'b0;
  logic reset_i = 1'b1;
  always #5 digiclk_i = ~digiclk_i;

  logic [CNT_W-1:0] src_rdcnt_i = '0;
  logic [IN_W-1:0]  src_data_i = '0;
  logic             src_re_o, dst_we_o, busy_o;
  logic             dst_afull_i = 1'b0;
  logic [OUT_W-1:0] dst_data_o;
  logic             mem_en_i = 1'b0, ddr_full_i = 1'b0, last_write_i = 1'b0;
  logic [31:0]      words_out_o;
  state_t           dbg_state;

  fifo_packer_nx1 #(.IN_W(IN_W), .RATIO(RATIO), .CNT_W(CNT_W), .BURST(BURST), .PAD(PAD)) dut (
    .digiclk_i(digiclk_i), .reset_i(reset_i), .src_rdcnt_i(src_rdcnt_i), .src_data_i(src_data_i),
    .src_re_o(src_re_o), .dst_afull_i(dst_afull_i), .dst_we_o(dst_we_o), .dst_data_o(dst_data_o),
    .mem_en_i(mem_en_i), .ddr_full_i(ddr_full_i), .last_write_i(last_write_i), .busy_o(busy_o),
    .words_out_o(words_out_o), .dbg_state(dbg_state)
  );

  // reference model state
  logic [IN_W-1:0]  src_q[$];
  logic [IN_W-1:0]  part_q[$];
  logic [OUT_W-1:0] exp_q[$];
  logic             re_seen = 1'b0;
  logic [31:0]      words_exp = '0;
  logic [OUT_W-1:0] first_data = '0;
  bit               grab_first = 1'b0;
  bit               hold_afull = 1'b0, rand_afull = 1'b0;
  int               n_reads = 0, n_writes = 0, gap = 0, max_gap = 0;
  int               n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // source FIFO: read data appears the cycle after a sampled src_re_o
  always @(posedge digiclk_i) begin
    logic [IN_W-1:0]  w;
    logic [OUT_W-1:0] pk;
    #1;
    if (re_seen) begin
      check("src_underflow", 128'(src_q.size() != 0), 128'd1);
      if (src_q.size() != 0) begin
        w = src_q.pop_front();
        src_data_i = w;
        part_q.push_back(w);
        if (part_q.size() == RATIO) begin
          pk = '0;
          for (int i = 0; i < RATIO; i++) pk[i*IN_W +: IN_W] = part_q[i];
          exp_q.push_back(pk);
          part_q.delete();
        end
      end
    end
    src_rdcnt_i = CNT_W'(src_q.size());
  end

  always @(posedge digiclk_i) begin
    #3;
    dst_afull_i = hold_afull || (rand_afull && ($urandom_range(0, 3) == 0));
  end

  // scoreboard / monitor
  always @(negedge digiclk_i) begin
    re_seen = src_re_o;
    if (src_re_o) begin
      n_reads++;
      if (gap > max_gap) max_gap = gap;
      gap = 0;
    end else if (busy_o) gap++;
    else gap = 0;
    if (dst_we_o) begin
      n_writes++;
      words_exp = words_exp + 32'd1;
      if (grab_first) begin
        first_data = dst_data_o;
        grab_first = 1'b0;
      end
      check("write_expected", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) check("dst_data", dst_data_o, exp_q.pop_front());
      check("words_out", words_out_o, words_exp);
    end
  end

  // driver tasks
  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) src_q.push_back($urandom());
  endtask

  task automatic pulse(input bit en, input bit full, input bit last);
    @(negedge digiclk_i);
    mem_en_i = en; ddr_full_i = full; last_write_i = last;
    @(negedge digiclk_i);
    mem_en_i = 1'b0; ddr_full_i = 1'b0; last_write_i = 1'b0;
  endtask

  task automatic wait_quiet(input string tag);
    int  quiet = 0;
    bit  ok = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge digiclk_i); #2;
      if (!busy_o && exp_q.size() == 0 && !dst_we_o) quiet++;
      else quiet = 0;
      if (quiet >= 4) begin ok = 1'b1; break; end
    end
    check({tag, "_done"}, 128'(ok), 128'd1);
  endtask

  task automatic wait_reads(input int target, input string tag);
    bit ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge digiclk_i); #2;
      if (n_reads >= target) begin ok = 1'b1; break; end
    end
    check({tag, "_reads_reached"}, 128'(ok), 128'd1);
  endtask

  function automatic logic [OUT_W-1:0] head_word();
    logic [OUT_W-1:0] pk = '0;
    for (int i = 0; i < RATIO; i++) pk[i*IN_W +: IN_W] = src_q[i];
    return pk;
  endfunction

  initial begin
    int r0, w0, pushed;
    logic [OUT_W-1:0] exp_first;

    // reset state
    repeat (3) @(negedge digiclk_i);
    check("rst_src_re", 128'(src_re_o), 128'd0);
    check("rst_dst_we", 128'(dst_we_o), 128'd0);
    check("rst_dst_data", dst_data_o, 128'd0);
    check("rst_busy", 128'(busy_o), 128'd0);
    check("rst_words_out", words_out_o, 128'd0);
    reset_i = 1'b0;

    // arming blocked by ddr_full, and by last_write in the same cycle
    push_words(2 * BURST);
    r0 = n_reads;
    pulse(1'b1, 1'b1, 1'b0);
    repeat (30) @(negedge digiclk_i);
    check("ddr_full_no_reads", n_reads - r0, 128'd0);
    pulse(1'b1, 1'b0, 1'b1);
    repeat (30) @(negedge digiclk_i);
    check("last_wins_no_reads", n_reads - r0, 128'd0);

    // two back-to-back bursts
    exp_first = head_word();
    grab_first = 1'b1;
    r0 = n_reads; w0 = n_writes;
    pulse(1'b1, 1'b0, 1'b0);
    wait_quiet("burst");
    check("burst_reads", n_reads - r0, 128'(2 * BURST));
    check("burst_writes", n_writes - w0, 128'(2 * BURST / RATIO));
    check("burst_first_data", first_data, exp_first);
    check("burst_words_out", words_out_o, 128'(2 * BURST / RATIO));
    check("burst_busy_low", 128'(busy_o), 128'd0);

    // dst_afull held for 5 cycles mid-burst
    r0 = n_reads; w0 = n_writes; max_gap = 0;
    push_words(BURST);
    wait_reads(r0 + 6, "throttle");
    hold_afull = 1'b1;
    repeat (5) @(negedge digiclk_i);
    hold_afull = 1'b0;
    wait_quiet("throttle");
    check("throttle_gap_ge5", 128'(max_gap >= 5), 128'd1);
    check("throttle_reads", n_reads - r0, 128'(BURST));
    check("throttle_writes", n_writes - w0, 128'(BURST / RATIO));

    // random data and random back-pressure
    rand_afull = 1'b1;
    r0 = n_reads; pushed = 0;
    for (int k = 0; k < 6; k++) begin
      int n = BURST * $urandom_range(1, 3);
      push_words(n);
      pushed += n;
      wait_quiet("random");
    end
    rand_afull = 1'b0;
    check("random_reads", n_reads - r0, 128'(pushed));
    check("random_src_empty", 128'(src_q.size()), 128'd0);

    // words_out wraps at 2^32
    @(negedge digiclk_i);
    force dut.words_out_o = 32'hFFFF_FFFF;
    #1 release dut.words_out_o;
    words_exp = 32'hFFFF_FFFF;
    push_words(BURST);
    wait_quiet("wrap");
    check("wrap_words_out", words_out_o, 128'(BURST / RATIO - 1));

    // end of run with 5 residual words
    r0 = n_reads; w0 = n_writes;
    push_words(5);
    repeat (4) @(negedge digiclk_i);
    pulse(1'b0, 1'b0, 1'b1);
`ifdef FIFO_PACKER_FLUSH_EN
    begin
      bit drained = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge digiclk_i);
        if (src_q.size() == 0) begin drained = 1'b1; break; end
      end
      check("flush_drained", 128'(drained), 128'd1);
      @(negedge digiclk_i); #2;
      if (part_q.size() != 0) begin
        logic [OUT_W-1:0] pk = {RATIO{PAD}};
        for (int i = 0; i < part_q.size(); i++) pk[i*IN_W +: IN_W] = part_q[i];
        exp_q.push_back(pk);
        part_q.delete();
      end
      wait_quiet("flush");
      check("flush_reads", n_reads - r0, 128'd5);
      check("flush_writes", n_writes - w0, 128'd2);
    end
`else
    repeat (40) @(negedge digiclk_i);
    check("noflush_reads", n_reads - r0, 128'd0);
    check("noflush_writes", n_writes - w0, 128'd0);
    src_q.delete();
    repeat (3) @(negedge digiclk_i);
`endif

    // asynchronous reset in the middle of a burst
    pulse(1'b1, 1'b0, 1'b0);
    r0 = n_reads;
    push_words(2 * BURST);
    wait_reads(r0 + 7, "midrst");
    @(posedge digiclk_i); #2;
    reset_i = 1'b1;
    part_q.delete();
    exp_q.delete();
    #1;
    check("midrst_src_re", 128'(src_re_o), 128'd0);
    check("midrst_dst_we", 128'(dst_we_o), 128'd0);
    check("midrst_dst_data", dst_data_o, 128'd0);
    check("midrst_busy", 128'(busy_o), 128'd0);
    check("midrst_words_out", words_out_o, 128'd0);
    words_exp = '0;
    src_q.delete();
    repeat (3) @(negedge digiclk_i);
    reset_i = 1'b0;
    repeat (2) @(negedge digiclk_i);
    r0 = n_reads; w0 = n_writes;
    push_words(BURST);
    exp_first = head_word();
    grab_first = 1'b1;
    pulse(1'b1, 1'b0, 1'b0);
    wait_quiet("postrst");
    check("postrst_reads", n_reads - r0, 128'(BURST));
    check("postrst_writes", n_writes - w0, 128'(BURST / RATIO));
    check("postrst_first_data", first_data, exp_first);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
